exec_unit_pipe: RTL and testbench
=================================

// Module: exec_unit_pipe
// PURPOSE
//  Parametrised Tomasulo functional unit. Accepts one op from a reservation station and
//  computes ADD/SUB/MUL/DIV/logic/SLT with op-dependent latency. Broadcasts result, ROB
//  tag and dest reg on the CDB through a valid/ready handshake. One op in flight.
//  Supports pipeline flush on branch mispredict.
// PARAMETERS
//  DATA_W   8  operand/result width (>=4)
//  TAG_W    3  ROB index width
//  REG_W    4  destination register index width
//  MUL_LAT  2  multiply latency in cycles (>=1)
// PORTS
//  clk1         in   1        clock, rising edge
//  rst_n        in   1        async active-low reset
//  flush        in   1        sync kill of in-flight/pending op
//  issue_valid  in   1        RS presents op
//  issue_ready  out  1        unit can accept op this cycle
//  func         in   4        opcode (see BEHAVIOUR)
//  rs1_data     in   DATA_W   operand A
//  rs2_data     in   DATA_W   operand B
//  rob_ind      in   TAG_W    ROB tag of op
//  rd           in   REG_W    destination register
//  cdb_valid    out  1        result valid on CDB
//  cdb_ready    in   1        CDB arbiter grants broadcast
//  cdb_data     out  DATA_W   result
//  cdb_tag      out  TAG_W    ROB tag of result
//  cdb_rd       out  REG_W    dest reg of result
//  cdb_exc      out  1        exception: div-by-zero or illegal func
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; issue_ready=1 after release; cdb_valid=0.
//    cdb_data/tag/rd/exc reset to 0. Counters and divider regs reset to 0.
//  - Issue: op accepted on posedge when issue_valid && issue_ready && !flush.
//    Operands, func, rob_ind and rd are latched. Inputs are ignored otherwise.
//  - issue_ready = !flush && (state==IDLE || (state==WB && cdb_ready)).
//    Back-to-back issue is allowed on the cycle the result retires.
//  - FSM: IDLE -accept-> EXEC (or WB directly for 1-cycle ops); EXEC -count done-> WB;
//    WB -cdb_ready-> IDLE, or EXEC/WB if a new op is accepted the same cycle.
//  - Latency (accept edge to first cdb_valid cycle): ADD/SUB/AND/OR/XOR/SLT = 1;
//    MUL = MUL_LAT; DIV = DATA_W+1.
//  - func: 0000 A+B; 0001 A-B; 0010 A*B (low DATA_W bits); 0011 A/B unsigned;
//    0100 A&B; 0101 A|B; 0110 A^B; 0111 SLT signed (1 or 0).
//    ADD/SUB wrap modulo 2^DATA_W.
//  - DIV: restoring, 1 quotient bit per cycle, MSB first. If B==0: data = all ones,
//    cdb_exc=1, same DIV latency.
//  - Illegal func (1xxx): data=0, cdb_exc=1, latency 1.
//  - WB: cdb_* held stable while cdb_valid && !cdb_ready, for any number of cycles.
//    cdb_valid drops the cycle after handshake unless a new 1-cycle op was accepted.
//  - flush: has priority over all. Next state IDLE, cdb_valid=0 next cycle, pending
//    result dropped. No issue accepted in a flush cycle. A result handshaking in the
//    same cycle as flush still counts as delivered.
//  - Reset mid-operation aborts immediately; no partial result is broadcast.
// TESTING
//  - ADD 8'd200+8'd100, tag 5, rd 3, cdb_ready=1 -> 1 cycle later data=44, tag=5,
//    rd=3, exc=0.
//  - MUL 8'd13*8'd11, MUL_LAT=2 -> valid 2 cycles after accept, data=8'h8F;
//    issue_ready low meanwhile.
//  - DIV 8'd100/8'd7 -> valid after 9 cycles, data=14; DIV 5/0 -> data=8'hFF, exc=1.
//  - Stall: result valid, cdb_ready=0 for 4 cycles -> outputs stable, issue_ready=0;
//    then ready=1 with a new ADD issued the same cycle -> next result valid the next cycle.
//  - flush during DIV cycle 3 -> cdb_valid never asserts, IDLE next cycle;
//    issue in the flush cycle is refused.
//  - rst_n low mid-MUL -> all outputs 0 asynchronously; after release, SLT -1<1
//    -> data=1 in 1 cycle.

Source files
------------

// File: rtl/exec_unit_pipe_if.sv
// Issue-side and CDB-side handshake bundle for the execution unit.
// slave = the unit itself, master = reservation station / CDB arbiter side.
interface exec_unit_pipe_if #(
    parameter int DATA_W = 8,
    parameter int TAG_W  = 3,
    parameter int REG_W  = 4
);
    logic              issue_valid;
    logic              issue_ready;
    logic [3:0]        func;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [TAG_W-1:0]  rob_ind;
    logic [REG_W-1:0]  rd;
    logic              cdb_valid;
    logic              cdb_ready;
    logic [DATA_W-1:0] cdb_data;
    logic [TAG_W-1:0]  cdb_tag;
    logic [REG_W-1:0]  cdb_rd;
    logic              cdb_exc;

    modport slave (
        input  issue_valid, func, rs1_data, rs2_data, rob_ind, rd, cdb_ready,
        output issue_ready, cdb_valid, cdb_data, cdb_tag, cdb_rd, cdb_exc
    );

    modport master (
        output issue_valid, func, rs1_data, rs2_data, rob_ind, rd, cdb_ready,
        input  issue_ready, cdb_valid, cdb_data, cdb_tag, cdb_rd, cdb_exc
    );
endinterface

// File: rtl/exec_unit_pipe.sv
// Single-op Tomasulo functional unit: ALU/SLT in one cycle, multi-cycle MUL,
// restoring divider, result broadcast on the CDB with valid/ready and flush support.
module exec_unit_pipe #(
    parameter int DATA_W  = 8,
    parameter int TAG_W   = 3,
    parameter int REG_W   = 4,
    parameter int MUL_LAT = 2
) (
    input  logic            clk1,
    input  logic            rst_n,
    input  logic            flush,
    exec_unit_pipe_if.slave bus
);
    localparam logic [3:0] F_ADD = 4'd0;
    localparam logic [3:0] F_SUB = 4'd1;
    localparam logic [3:0] F_MUL = 4'd2;
    localparam logic [3:0] F_DIV = 4'd3;
    localparam logic [3:0] F_AND = 4'd4;
    localparam logic [3:0] F_OR  = 4'd5;
    localparam logic [3:0] F_XOR = 4'd6;
    localparam logic [3:0] F_SLT = 4'd7;

    localparam int CNT_MAX = (DATA_W > MUL_LAT) ? DATA_W : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    // EXEC lasts latency-1 cycles; the counter is loaded with that minus one.
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] MUL_CNT = (MUL_LAT >= 2) ? CNT_W'(MUL_LAT - 2) : '0;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] a_reg, b_reg, rem_reg, quo_reg;
    logic              is_div_reg;
    logic [DATA_W-1:0] cdb_data_reg;
    logic [TAG_W-1:0]  cdb_tag_reg;
    logic [REG_W-1:0]  cdb_rd_reg;
    logic              cdb_exc_reg;

    logic              issue_ready;
    logic              accept;
    logic              single_cycle;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] mul_res;
    logic [DATA_W:0]   rem_shift, diff;
    logic [DATA_W-1:0] rem_step, quo_step;
    logic              b_zero;

    assign accept = bus.issue_valid && issue_ready;
    assign single_cycle = bus.func[3] || !((bus.func == F_MUL) || (bus.func == F_DIV))
                          || ((bus.func == F_MUL) && (MUL_LAT == 1));

    always_comb begin
        alu_res = '0;
        case (bus.func)
            F_ADD:   alu_res = bus.rs1_data + bus.rs2_data;
            F_SUB:   alu_res = bus.rs1_data - bus.rs2_data;
            F_MUL:   alu_res = bus.rs1_data * bus.rs2_data;
            F_AND:   alu_res = bus.rs1_data & bus.rs2_data;
            F_OR:    alu_res = bus.rs1_data | bus.rs2_data;
            F_XOR:   alu_res = bus.rs1_data ^ bus.rs2_data;
            F_SLT:   alu_res = {{(DATA_W-1){1'b0}},
                                ($signed(bus.rs1_data) < $signed(bus.rs2_data))};
            default: alu_res = '0;
        endcase
    end

    // One restoring-division step; diff[DATA_W] is the borrow (trial subtract failed).
    assign b_zero    = (b_reg == '0);
    assign rem_shift = {rem_reg, quo_reg[DATA_W-1]};
    assign diff      = rem_shift - {1'b0, b_reg};
    assign rem_step  = diff[DATA_W] ? rem_shift[DATA_W-1:0] : diff[DATA_W-1:0];
    assign quo_step  = {quo_reg[DATA_W-2:0], (~diff[DATA_W]) | b_zero};
    assign mul_res   = a_reg * b_reg;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: if (accept) state_next = single_cycle ? WB : EXEC;
                EXEC: if (cnt_reg == '0) state_next = WB;
                WB: begin
                    if (accept)             state_next = single_cycle ? WB : EXEC;
                    else if (bus.cdb_ready) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        issue_ready   = rst_n && !flush &&
                        ((state_reg == IDLE) || ((state_reg == WB) && bus.cdb_ready));
        bus.cdb_valid = (state_reg == WB);
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg      <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            is_div_reg   <= 1'b0;
            cdb_data_reg <= '0;
            cdb_tag_reg  <= '0;
            cdb_rd_reg   <= '0;
            cdb_exc_reg  <= 1'b0;
        end else if (accept) begin
            // tag/rd go straight to the CDB regs: any previous result retires this edge
            cdb_tag_reg <= bus.rob_ind;
            cdb_rd_reg  <= bus.rd;
            a_reg       <= bus.rs1_data;
            b_reg       <= bus.rs2_data;
            rem_reg     <= '0;
            quo_reg     <= bus.rs1_data;
            is_div_reg  <= (bus.func == F_DIV);
            cnt_reg     <= (bus.func == F_DIV) ? DIV_CNT : MUL_CNT;
            if (single_cycle) begin
                cdb_data_reg <= alu_res;
                cdb_exc_reg  <= bus.func[3];
            end
        end else if ((state_reg == EXEC) && !flush) begin
            if (is_div_reg) begin
                rem_reg <= rem_step;
                quo_reg <= quo_step;
            end
            if (cnt_reg == '0) begin
                cdb_data_reg <= is_div_reg ? quo_step : mul_res;
                cdb_exc_reg  <= is_div_reg && b_zero;
            end else begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end
        end
    end

    assign bus.issue_ready = issue_ready;
    assign bus.cdb_data    = cdb_data_reg;
    assign bus.cdb_tag     = cdb_tag_reg;
    assign bus.cdb_rd      = cdb_rd_reg;
    assign bus.cdb_exc     = cdb_exc_reg;
endmodule

// File: tb/tb_exec_unit_pipe.sv
// Directed bench for exec_unit_pipe: inputs driven and outputs checked on the
// falling edge, expected values worked out by hand.
module tb_exec_unit_pipe;
    logic clk1 = 1'b0;
    logic rst_n;
    logic flush;
    int   total = 0;
    int   bad   = 0;

    exec_unit_pipe_if #(.DATA_W(8), .TAG_W(3), .REG_W(4)) bus ();

    exec_unit_pipe #(.DATA_W(8), .TAG_W(3), .REG_W(4), .MUL_LAT(2)) dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk1 = ~clk1;

    task automatic tick();
        @(negedge clk1);
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic set_issue(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                             input logic [2:0] t, input logic [3:0] r);
        bus.issue_valid = 1'b1;
        bus.func        = f;
        bus.rs1_data    = a;
        bus.rs2_data    = b;
        bus.rob_ind     = t;
        bus.rd          = r;
    endtask

    task automatic drop_issue();
        bus.issue_valid = 1'b0;
    endtask

    // Issue a 1-cycle op now; result must be on the CDB at the next falling edge.
    task automatic run1(input string name, input logic [3:0] f, input logic [7:0] a,
                        input logic [7:0] b, input logic [2:0] t, input logic [3:0] r,
                        input logic [7:0] exp_data, input logic exp_exc);
        set_issue(f, a, b, t, r);
        tick();
        chk({name, "_valid"}, 32'(bus.cdb_valid), 32'd1);
        chk({name, "_data"},  32'(bus.cdb_data),  32'(exp_data));
        chk({name, "_tag"},   32'(bus.cdb_tag),   32'(t));
        chk({name, "_rd"},    32'(bus.cdb_rd),    32'(r));
        chk({name, "_exc"},   32'(bus.cdb_exc),   32'(exp_exc));
        drop_issue();
        $display("txn %s a=%0d b=%0d -> data=%0d exc=%0d", name, a, b, bus.cdb_data, bus.cdb_exc);
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        bus.issue_valid = 1'b0;
        bus.func = 4'd0;
        bus.rs1_data = 8'd0;
        bus.rs2_data = 8'd0;
        bus.rob_ind = 3'd0;
        bus.rd = 4'd0;
        bus.cdb_ready = 1'b1;

        tick(); tick();
        chk("rst_valid", 32'(bus.cdb_valid), 32'd0);
        chk("rst_data",  32'(bus.cdb_data),  32'd0);
        chk("rst_ready", 32'(bus.issue_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(bus.issue_ready), 32'd1);

        // 200+100 wraps to 44
        run1("add", 4'd0, 8'd200, 8'd100, 3'd5, 4'd3, 8'd44, 1'b0);
        tick();
        chk("add_retired", 32'(bus.cdb_valid), 32'd0);

        // back-to-back single-cycle ops, one accepted each cycle
        run1("sub_wrap", 4'd1, 8'd3,    8'd5,    3'd1, 4'd1, 8'hFE, 1'b0);
        run1("and",      4'd4, 8'hF0,   8'h3C,   3'd2, 4'd2, 8'h30, 1'b0);
        run1("or",       4'd5, 8'hF0,   8'h3C,   3'd3, 4'd3, 8'hFC, 1'b0);
        run1("xor",      4'd6, 8'hF0,   8'h3C,   3'd4, 4'd4, 8'hCC, 1'b0);
        run1("slt_neg",  4'd7, 8'h80,   8'h01,   3'd5, 4'd5, 8'd1,  1'b0);
        run1("slt_pos",  4'd7, 8'd5,    8'hFF,   3'd6, 4'd6, 8'd0,  1'b0);
        run1("illegal",  4'hA, 8'd3,    8'd4,    3'd7, 4'd7, 8'd0,  1'b1);
        tick();

        // MUL 13*11 = 143, two-cycle latency
        set_issue(4'd2, 8'd13, 8'd11, 3'd6, 4'd1);
        tick();
        chk("mul_busy_valid", 32'(bus.cdb_valid), 32'd0);
        chk("mul_busy_ready", 32'(bus.issue_ready), 32'd0);
        drop_issue();
        tick();
        chk("mul_valid", 32'(bus.cdb_valid), 32'd1);
        chk("mul_data",  32'(bus.cdb_data),  32'h8F);
        chk("mul_tag",   32'(bus.cdb_tag),   32'd6);
        $display("txn mul 13*11 -> data=0x%0h", bus.cdb_data);
        tick();
        chk("mul_retired", 32'(bus.cdb_valid), 32'd0);

        // DIV 100/7 = 14, valid on the 9th cycle
        set_issue(4'd3, 8'd100, 8'd7, 3'd3, 4'd5);
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 1) drop_issue();
            chk($sformatf("div_wait%0d", i), 32'(bus.cdb_valid), 32'd0);
        end
        tick();
        chk("div_valid", 32'(bus.cdb_valid), 32'd1);
        chk("div_data",  32'(bus.cdb_data),  32'd14);
        chk("div_exc",   32'(bus.cdb_exc),   32'd0);
        chk("div_rd",    32'(bus.cdb_rd),    32'd5);
        $display("txn div 100/7 -> data=%0d exc=%0d", bus.cdb_data, bus.cdb_exc);
        tick();

        // DIV 5/0 -> all ones, exception, same latency
        set_issue(4'd3, 8'd5, 8'd0, 3'd2, 4'd8);
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 1) drop_issue();
            chk($sformatf("div0_wait%0d", i), 32'(bus.cdb_valid), 32'd0);
        end
        tick();
        chk("div0_valid", 32'(bus.cdb_valid), 32'd1);
        chk("div0_data",  32'(bus.cdb_data),  32'hFF);
        chk("div0_exc",   32'(bus.cdb_exc),   32'd1);
        $display("txn div 5/0 -> data=0x%0h exc=%0d", bus.cdb_data, bus.cdb_exc);
        tick();

        // stall: result held while cdb_ready is low
        bus.cdb_ready = 1'b0;
        set_issue(4'd1, 8'd10, 8'd3, 3'd1, 4'd2);
        tick();
        chk("stall_first", 32'(bus.cdb_data), 32'd7);
        drop_issue();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("stall_valid%0d", i), 32'(bus.cdb_valid), 32'd1);
            chk($sformatf("stall_data%0d", i),  32'(bus.cdb_data),  32'd7);
            chk($sformatf("stall_tag%0d", i),   32'(bus.cdb_tag),   32'd1);
            chk($sformatf("stall_ready%0d", i), 32'(bus.issue_ready), 32'd0);
        end
        bus.cdb_ready = 1'b1;
        set_issue(4'd0, 8'd1, 8'd2, 3'd2, 4'd4);
        #1;
        chk("stall_release_ready", 32'(bus.issue_ready), 32'd1);
        tick();
        chk("b2b_valid", 32'(bus.cdb_valid), 32'd1);
        chk("b2b_data",  32'(bus.cdb_data),  32'd3);
        chk("b2b_tag",   32'(bus.cdb_tag),   32'd2);
        chk("b2b_rd",    32'(bus.cdb_rd),    32'd4);
        $display("txn stall then add 1+2 -> data=%0d tag=%0d", bus.cdb_data, bus.cdb_tag);
        drop_issue();
        tick();
        chk("b2b_retired", 32'(bus.cdb_valid), 32'd0);

        // flush in DIV cycle 3, with an issue attempt in the flush cycle
        set_issue(4'd3, 8'd200, 8'd3, 3'd4, 4'd6);
        tick();
        drop_issue();
        tick();
        tick();
        flush = 1'b1;
        set_issue(4'd0, 8'd1, 8'd1, 3'd7, 4'd7);
        #1;
        chk("flush_ready", 32'(bus.issue_ready), 32'd0);
        tick();
        flush = 1'b0;
        drop_issue();
        #1;
        chk("flush_idle_ready", 32'(bus.issue_ready), 32'd1);
        chk("flush_valid", 32'(bus.cdb_valid), 32'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("flush_quiet%0d", i), 32'(bus.cdb_valid), 32'd0);
        end
        $display("txn div flushed in cycle 3 -> no broadcast");

        // reset in the middle of a MUL
        set_issue(4'd2, 8'd13, 8'd11, 3'd6, 4'd5);
        tick();
        drop_issue();
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.cdb_valid), 32'd0);
        chk("arst_data",  32'(bus.cdb_data),  32'd0);
        chk("arst_tag",   32'(bus.cdb_tag),   32'd0);
        chk("arst_rd",    32'(bus.cdb_rd),    32'd0);
        chk("arst_exc",   32'(bus.cdb_exc),   32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_after_valid", 32'(bus.cdb_valid), 32'd0);
        chk("arst_after_ready", 32'(bus.issue_ready), 32'd1);
        run1("slt_after_rst", 4'd7, 8'hFF, 8'h01, 3'd2, 4'd9, 8'd1, 1'b0);
        tick();
        chk("final_idle", 32'(bus.cdb_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
